// File: rtl/mdu.sv
// mdu: multiply/divide unit beside Execute, owns HI/LO.
// Optional multiply-accumulate ops (7..10) are built when MDU_MADD_EN is defined.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - op request, sampled at rising edge while idle
//   op     - 4-bit op code (NOP/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MADD..MSUBU)
//   rs_val - operand A, dividend, or MTHI/MTLO value
//   rt_val - operand B, divisor
//   busy   - registered, high while a multi-cycle op is in flight
//   hi, lo - HI/LO registers
module mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [31:0]   a_q, b_q;
    logic          sgn_q;
    logic [31:0]   hi_q, lo_q, hi_d, lo_d;

    logic dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;
`ifdef MDU_MADD_EN
    logic dec_acc, dec_sub;
    logic acc_q, sub_q;
`endif
    logic accept;

    // Op decode
    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
`ifdef MDU_MADD_EN
        dec_acc  = 1'b0;
        dec_sub  = 1'b0;
`endif
        unique case (1'b1)
            (op == 4'd1): begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            (op == 4'd2): dec_mul = 1'b1;
            (op == 4'd3): begin dec_div = 1'b1; dec_sgn = 1'b1; end
            (op == 4'd4): dec_div = 1'b1;
            (op == 4'd5): dec_mthi = 1'b1;
            (op == 4'd6): dec_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            (op == 4'd7): begin
                dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = 1'b1;
            end
            (op == 4'd8): begin
                dec_mul = 1'b1; dec_acc = 1'b1;
            end
            (op == 4'd9): begin
                dec_mul = 1'b1; dec_sgn = 1'b1;
                dec_acc = 1'b1; dec_sub = 1'b1;
            end
            (op == 4'd10): begin
                dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign accept = start && (state_q == S_IDLE);

    // State register, counter and operand latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            if (accept && dec_mul)
                cnt_q <= CW'(MUL_CYCLES);
            else if (accept && dec_div)
                cnt_q <= CW'(DIV_CYCLES);
            else if (state_q != S_IDLE)
                cnt_q <= cnt_q - CW'(1);
            if (accept && (dec_mul || dec_div)) begin
                a_q   <= rs_val;
                b_q   <= rt_val;
                sgn_q <= dec_sgn;
`ifdef MDU_MADD_EN
                acc_q <= dec_acc;
                sub_q <= dec_sub;
`endif
            end
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && dec_mul)
                    state_d = S_MUL;
                else if (accept && dec_div)
                    state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (cnt_q == CW'(1))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operands are sign- or zero-extended to 64 bits so a single
    // unsigned multiplier yields the correct low 64 bits for both flavours.
    logic [63:0] ea, eb, prod, mul_res;
    assign ea   = {{32{sgn_q & a_q[31]}}, a_q};
    assign eb   = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod = ea * eb;

`ifdef MDU_MADD_EN
    logic [63:0] hilo;
    assign hilo    = {hi_q, lo_q};
    assign mul_res = !acc_q ? prod :
                     sub_q  ? (hilo - prod) : (hilo + prod);
`else
    assign mul_res = prod;
`endif

    // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally
    // as quotient 0x80000000, remainder 0.
    logic        neg_a, neg_b;
    logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;
    assign neg_a   = sgn_q & a_q[31];
    assign neg_b   = sgn_q & b_q[31];
    assign ua      = neg_a ? (32'd0 - a_q) : a_q;
    assign ub      = neg_b ? (32'd0 - b_q) : b_q;
    assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    assign uq      = ua / ub_safe;
    assign ur      = ua % ub_safe;
    assign quo     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem     = neg_a ? (32'd0 - ur) : ur;

    // Output / commit
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_IDLE) begin
            if (accept && dec_mthi) hi_d = rs_val;
            if (accept && dec_mtlo) lo_d = rs_val;
        end else if (cnt_q == CW'(1)) begin
            if (state_q == S_MUL) begin
                {hi_d, lo_d} = mul_res;
            end else if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized + directed bench for mdu against a plain-arithmetic
// HI/LO model.
module tb_mdu;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: applies an op to the HI/LO model, returns busy cycles.
    function automatic int model_op(input logic [3:0] o,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {m_hi, m_lo};
        case (o)
            4'd1: begin {m_hi, m_lo} = sa * sb; return MULC; end
            4'd2: begin {m_hi, m_lo} = ua * ub; return MULC; end
            4'd3: begin
                if (b != 0) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
                return DIVC;
            end
            4'd4: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                return DIVC;
            end
            4'd5: begin m_hi = a; return 0; end
            4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            4'd7:  begin {m_hi, m_lo} = acc + 64'(sa * sb); return MULC; end
            4'd8:  begin {m_hi, m_lo} = acc + ua * ub;      return MULC; end
            4'd9:  begin {m_hi, m_lo} = acc - 64'(sa * sb); return MULC; end
            4'd10: begin {m_hi, m_lo} = acc - ua * ub;      return MULC; end
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op; optionally poke an ignored start at busy cycle poke_at.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int poke_at);
        int n;
        int lat;
        lat = model_op(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 200) begin
            if (n == poke_at && poke_at > 0) begin
                @(negedge clk);
                start = 1'b1; op = 4'd4;
                rs_val = $urandom; rt_val = 32'd3;
                @(posedge clk); #1;
                start = 1'b0; op = 4'd0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(lat));
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b0; start = 1'b0; op = 4'd0;
        rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.hi", 64'(hi), 64'd0);
        check("rst.lo", 64'(lo), 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rel.busy", 64'(busy), 64'd0);
        check("rel.hilo", {hi, lo}, 64'd0);

        run_op("mult",  4'd1, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult.k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu.k", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        check("div.k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 0);
        check("divu0.k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("mthi",  4'd5, 32'h1234, 32'd0, 0);
        check("mthi.k", 64'(hi), 64'h1234);
        run_op("poke",  4'd1, 32'd1000, 32'hFFFF_FFFD, 2);
        run_op("ovf",   4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("ovf.k", {hi, lo}, 64'h0000_0000_8000_0000);

        // Async reset at busy cycle 3 of a DIV
        @(negedge clk);
        start = 1'b1; op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hilo", {hi, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk); reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort.nocommit", {hi, lo}, 64'd0);
        run_op("mtlo", 4'd6, 32'd5, 32'd0, 0);
        check("mtlo.k", 64'(lo), 64'd5);

`ifdef MDU_MADD_EN
        run_op("h0", 4'd5, 32'd0, 32'd0, 0);
        run_op("lF", 4'd6, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("maddu", 4'd8, 32'd1, 32'd1, 0);
        check("maddu.k", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op("h0b", 4'd5, 32'd0, 32'd0, 0);
        run_op("l0b", 4'd6, 32'd0, 32'd0, 0);
        run_op("msub", 4'd9, 32'd1, 32'd1, 0);
        check("msub.k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        run_op("hA", 4'd5, 32'hA, 32'd0, 0);
        run_op("op7", 4'd7, 32'd3, 32'd4, 0);
        check("op7.k", {hi, lo}, 64'h0000_000A_0000_0005);
`endif

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), ro, ra, rb,
                   ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
